// File: rtl/demux_3out_32data.sv
// Registered 1-to-3 demux, 1-cycle latency; in_ready follows only the selected slot (full and not draining stalls). Select 2'b11 is always accepted, dropped and flagged.
// Optional per-output/drop transfer counters are enabled by DEMUX_PERF_CNT_EN.
module demux_3out_32data #(
   parameter int DATA_W = 32
`ifdef DEMUX_PERF_CNT_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        select,
   output logic [DATA_W-1:0] out_data_0,
   output logic              out_valid_0,
   input  logic              out_ready_0,
   output logic [DATA_W-1:0] out_data_1,
   output logic              out_valid_1,
   input  logic              out_ready_1,
   output logic [DATA_W-1:0] out_data_2,
   output logic              out_valid_2,
   input  logic              out_ready_2,
   output logic              err_sel
`ifdef DEMUX_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  cnt_0,
   output logic [CNT_W-1:0]  cnt_1,
   output logic [CNT_W-1:0]  cnt_2,
   output logic [CNT_W-1:0]  cnt_drop
`endif
);

   logic [2:0]        valid_q, valid_d;
   logic [DATA_W-1:0] data_q [3];
   logic [DATA_W-1:0] data_d [3];
   logic              err_q, err_d;

   logic [2:0]        out_rdy;
   logic [2:0]        out_xfer;
   logic [2:0]        load;
   logic              in_xfer;
   logic              drop;

   always_comb begin
      out_rdy = {out_ready_2, out_ready_1, out_ready_0};

      // A full slot can take a new word in the same cycle it drains.
      case (select)
         2'd0:    in_ready = !valid_q[0] || out_rdy[0];
         2'd1:    in_ready = !valid_q[1] || out_rdy[1];
         2'd2:    in_ready = !valid_q[2] || out_rdy[2];
         default: in_ready = 1'b1;
      endcase

      in_xfer  = in_valid && in_ready;
      drop     = in_xfer && (select == 2'b11);
      load     = '0;
      out_xfer = '0;
      valid_d  = valid_q;
      for (int k = 0; k < 3; k++) begin
         load[k]     = in_xfer && (select == 2'(k));
         out_xfer[k] = valid_q[k] && out_rdy[k];
         valid_d[k]  = load[k] || (valid_q[k] && !out_xfer[k]);
         data_d[k]   = load[k] ? in_data : data_q[k];
      end
      err_d = err_q || drop;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int k = 0; k < 3; k++) data_q[k] <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < 3; k++) data_q[k] <= data_d[k];
         err_q   <= err_d;
      end
   end

   assign out_valid_0 = valid_q[0];
   assign out_valid_1 = valid_q[1];
   assign out_valid_2 = valid_q[2];
   assign out_data_0  = data_q[0];
   assign out_data_1  = data_q[1];
   assign out_data_2  = data_q[2];
   assign err_sel     = err_q;

`ifdef DEMUX_PERF_CNT_EN
   // Index 3 counts dropped (select == 2'b11) transfers; all wrap naturally.
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];

   always_comb begin
      for (int k = 0; k < 3; k++) cnt_d[k] = cnt_q[k] + CNT_W'(out_xfer[k]);
      cnt_d[3] = cnt_q[3] + CNT_W'(drop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   assign cnt_0    = cnt_q[0];
   assign cnt_1    = cnt_q[1];
   assign cnt_2    = cnt_q[2];
   assign cnt_drop = cnt_q[3];
`endif

endmodule
